// File: rtl/aes_key_expand128.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expand128 (with helper module sbox)
//  Description : Iterative AES-128 key schedule. Emits round keys 0..10 one
//                per accepted handshake, deriving each key from the previous
//                one through four byte substitutions and an XOR chain.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  sbox : AES forward byte substitution as a constant lookup table.
// ----------------------------------------------------------------------------
module sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    // Byte 0x00 occupies the most significant byte of the table.
    localparam logic [2047:0] C_SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry n sits (255-n) bytes above bit 0; 255-n is simply ~n.
    logic [10:0] w_base;
    assign w_base = {~in_i, 3'b000};
    assign out_o  = C_SBOX_TABLE[w_base +: 8];
endmodule

// ----------------------------------------------------------------------------
//  aes_key_expand128 : top-level key schedule sequencer.
// ----------------------------------------------------------------------------
module aes_key_expand128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);
    localparam logic [3:0] C_LAST_ROUND = 4'd10;
    localparam logic [7:0] C_RCON_INIT  = 8'h01;
    localparam logic [7:0] C_RCON_POLY  = 8'h1b;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] rk_q,    rk_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q,  rcon_d;
    logic         done_q,  done_d;

    // Key schedule datapath: next round key from the current one.
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot, w_sub, w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next_rk;
    logic [7:0]   w_rcon_next;

    assign w_w0  = rk_q[127:96];
    assign w_w1  = rk_q[95:64];
    assign w_w2  = rk_q[63:32];
    assign w_w3  = rk_q[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            sbox u_sbox (
                .in_i  (w_rot[8*gi +: 8]),
                .out_o (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    assign w_t       = w_sub ^ {rcon_q, 24'h000000};
    assign w_n0      = w_w0 ^ w_t;
    assign w_n1      = w_w1 ^ w_n0;
    assign w_n2      = w_w2 ^ w_n1;
    assign w_n3      = w_w3 ^ w_n2;
    assign w_next_rk = {w_n0, w_n1, w_n2, w_n3};

    // Multiply rcon by x in GF(2^8).
    assign w_rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? C_RCON_POLY : 8'h00);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rk_q    <= 128'h0;
            round_q <= 4'd0;
            rcon_q  <= C_RCON_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: load on start, advance on each accepted key,
    // return to idle once round 10 has been taken.
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rk_d    = key;
                    round_d = 4'd0;
                    rcon_d  = C_RCON_INIT;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // rk_valid is high throughout RUN, so rk_ready alone
                // completes the handshake.
                if (rk_ready) begin
                    if (round_q == C_LAST_ROUND) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rk_d    = w_next_rk;
                        round_d = round_q + 4'd1;
                        rcon_d  = w_rcon_next;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rk_valid = (state_q == S_RUN);
    assign busy     = (state_q == S_RUN);
    assign rk       = rk_q;
    assign rk_round = round_q;
    assign done     = done_q;
endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand128.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_expand128
//  Description : Self-checking bench for the AES-128 key schedule, using a
//                FIPS-197 style word-expansion model with a computed S-box.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand128;
    localparam logic [127:0] C_KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] C_A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_Z_R1    = 128'h62636363626363636263636362636363;
    localparam logic [127:0] C_Z_R10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc;

    logic [127:0] exp_k [0:10];
    logic [127:0] obs_k [0:10];

    aes_key_expand128 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // GF(2^8) multiply, AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    // Textbook 44-word expansion, grouped into 11 round keys.
    function automatic void expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]),
                     sbox_ref(t[15:8]),  sbox_ref(t[7:0])};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++)
            exp_k[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endfunction

    task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Called at a falling edge; start is sampled at the next rising edge.
    task automatic do_start(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        expand(k);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Walk one expansion from round 0, checking every cycle. ign_at pulses a
    // start with a different key at that round; abort_at asserts rst there.
    task automatic follow(input bit rnd, input int ign_at, input int abort_at,
                          output int cycles);
        int r = 0;
        cycles = 0;
        while (r < 11) begin
            check("valid", {127'b0, rk_valid}, 128'd1);
            check("busy",  {127'b0, busy},     128'd1);
            check("done_low", {127'b0, done},  128'd0);
            check("round", {124'b0, rk_round}, r);
            check("rk",    rk, exp_k[r]);
            obs_k[r] = rk;
            if (r == abort_at) begin
                rst = 1'b1;
                rk_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                rk_ready = 1'b0;
                check("abort_valid", {127'b0, rk_valid}, 128'd0);
                check("abort_busy",  {127'b0, busy},     128'd0);
                check("abort_done",  {127'b0, done},     128'd0);
                @(negedge clk);
                check("abort_done2", {127'b0, done},     128'd0);
                return;
            end
            rk_ready = rnd ? 1'($urandom % 2) : 1'b1;
            if (r == ign_at) begin
                start = 1'b1;
                key   = ~key;
            end
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (rk_ready) r++;
            if (cycles > 400) begin
                check("timeout", cycles, 0);
                return;
            end
        end
        check("done_pulse", {127'b0, done},     128'd1);
        check("end_valid",  {127'b0, rk_valid}, 128'd0);
        check("end_busy",   {127'b0, busy},     128'd0);
        check("end_round",  {124'b0, rk_round}, 128'd10);
        check("end_rk",     rk, exp_k[10]);
        rk_ready = 1'b0;
    endtask

    initial begin
        // Reset with start held high: nothing may begin.
        rst = 1'b1; start = 1'b1; key = C_KEY_A1; rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {127'b0, rk_valid}, 128'd0);
        check("rst_busy",  {127'b0, busy},     128'd0);
        check("rst_done",  {127'b0, done},     128'd0);
        check("rst_rk",    rk,                 128'd0);
        check("rst_round", {124'b0, rk_round}, 128'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_valid", {127'b0, rk_valid}, 128'd0);

        // A.1 key, always ready, start pulsed alongside the final handshake.
        do_start(C_KEY_A1);
        follow(1'b0, 10, -1, cyc);
        check("a1_latency", cyc, 11);
        check("a1_r0",  obs_k[0],  C_KEY_A1);
        check("a1_r1",  obs_k[1],  C_A1_R1);
        check("a1_r10", obs_k[10], C_A1_R10);
        @(negedge clk);
        check("a1_done_once", {127'b0, done},     128'd0);
        check("a1_idle",      {127'b0, rk_valid}, 128'd0);
        check("a1_hold_rk",   rk,                 C_A1_R10);

        // Backpressure plus an ignored start at round 5.
        do_start(C_KEY_A1);
        follow(1'b1, 5, -1, cyc);
        check("bp_r1",  obs_k[1],  C_A1_R1);
        check("bp_r10", obs_k[10], C_A1_R10);

        // Back-to-back: start during the done cycle, zero key.
        do_start(128'h0);
        follow(1'b0, -1, -1, cyc);
        check("z_r0",  obs_k[0],  128'h0);
        check("z_r1",  obs_k[1],  C_Z_R1);
        check("z_r10", obs_k[10], C_Z_R10);
        @(negedge clk);

        // Abort at round 4, then a fresh A.1 expansion.
        do_start(C_KEY_A1);
        follow(1'b0, -1, 4, cyc);
        do_start(C_KEY_A1);
        follow(1'b0, -1, -1, cyc);
        check("restart_r1", obs_k[1], C_A1_R1);

        // Random keys under random backpressure.
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            do_start({$urandom, $urandom, $urandom, $urandom});
            follow(1'b1, -1, -1, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/aes_key_expand128.md
# aes_key_expand128

Iterative AES-128 key schedule generator. Takes a 128-bit cipher key and emits the 11 round keys (rounds 0..10) one at a time over a valid/ready handshake, computing each new key from the previous one with four instances of the existing `sbox` byte substitution. It sits beside `SubBytes` in the AES datapath and feeds the AddRoundKey stage of the iterative round core.

## Interface

**Parameters**
- none

**Ports** (clock and reset first)
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin an expansion; sampled only in IDLE.
- `key`  in  128  cipher key, FIPS-197 byte order: `key[127:120]` = byte 0; words w0=`key[127:96]` .. w3=`key[31:0]`. Sampled with `start`.
- `rk_valid`  out  1  `rk` and `rk_round` hold a valid round key.
- `rk_ready`  in  1  consumer accepts the current round key when high with `rk_valid`.
- `rk`  out  128  current round key, same word and byte order as `key`.
- `rk_round`  out  4  round index of `rk`, 0..10.
- `busy`  out  1  expansion in progress.
- `done`  out  1  one-cycle pulse after round key 10 is accepted.

## Operation

**FSM states:** IDLE and RUN.

**IDLE**
- On `start`=1, load `rk`←`key`, `rk_round`←0 and `rcon`←8'h01.
- Set `rk_valid`=1 and `busy`=1, then go to RUN.
- `start` while in RUN is ignored. No queuing.

**RUN**
- Handshake = `rk_valid & rk_ready`.
- With no handshake, `rk`, `rk_round` and `rcon` hold stable.
- On a handshake with `rk_round` < 10:
  - `rk`←next(`rk`), `rk_round`←`rk_round`+1.
  - `rcon`←xtime(`rcon`), i.e. {`rcon[6:0]`,0} ^ (`rcon[7]` ? 8'h1b : 0).
- On a handshake with `rk_round` = 10:
  - `rk_valid`←0, `busy`←0, `done`←1 for one cycle.
  - Go to IDLE. `rk` and `rk_round` keep their last values.

**next(rk)** is combinational from the `rk` register:
- t = SubWord(RotWord(w3)) ^ {`rcon`, 24'h0}.
- RotWord({a0,a1,a2,a3}) = {a1,a2,a3,a0}.
- SubWord applies `sbox` to each of the 4 bytes.
- w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- The rcon sequence used for rounds 1..10 is 01,02,04,08,10,20,40,80,1b,36.

**Boundary conditions**
- A `start` in the same cycle as the final handshake is ignored: the FSM is still in RUN that cycle.
- A `start` in the cycle `done` is high is accepted.
- `rk_ready` may be held high permanently; one key is delivered per cycle.
- `rst` mid-expansion aborts at the next edge. No `done` pulse is generated.

## Timing

- **Reset values:** `rk_valid`=0, `busy`=0, `done`=0, `rk`=128'h0, `rk_round`=0; internal `rcon`=8'h01, state IDLE.
- **Cycle timeline:** `start` sampled at edge E0.
  - Round 0 valid after E0.
  - With `rk_ready`=1 throughout, round k is valid in the cycle after edge Ek.
  - Round 10 is accepted at E11.
  - `done`=1 in the cycle after E11; `busy`=0 from that same cycle.
- **Throughput:** minimum 12 cycles per key expansion.
- **Critical path:** `rk` → 4× `sbox` → XOR chain (w0'..w3') → `rk` register. No internal pipelining.

## Test plan

- **Reset defaults:** assert `rst` 2 cycles, with `start`=1 during reset → all outputs 0; no expansion starts.
- **FIPS-197 A.1 key**, `key`=128'h2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1:
  - round 0 = key;
  - round 1 = 128'ha0fafe1788542cb123a339392a6c7605;
  - round 10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  - `done` pulses exactly once, 12 cycles after `start`.
- **All-zero key:**
  - round 1 = 128'h62636363626363636263636362636363;
  - round 10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e.
- **Backpressure:** random `rk_ready` (≈50%) with the A.1 key → identical 11-key sequence, with `rk`/`rk_round` stable while stalled; `done` follows the final accept by 1 cycle.
- **Ignored start:** pulse `start` with a different key at round 5 → sequence unchanged.
- **Back-to-back:** `start` during the `done` cycle with the zero key → new expansion; round 0 = 0 one cycle later.
- **Abort:** `rst` at round 4 → `rk_valid`=0 next cycle, no `done`; a following `start` with the A.1 key gives the correct round 1 (`rcon` restarted at 01).
